// File: rtl/whack_game_ctrl_if.sv
// Game-side signal bundle for whack_game_ctrl: player/timer inputs and
// the registered mole, score and status outputs.
interface whack_game_ctrl_if #(
    parameter int unsigned NUM_HOLES = 4
);
    logic                 start_btn;
    logic [NUM_HOLES-1:0] whack;
    logic                 timer_signal;
    logic                 game_start;
    logic                 timer_clear;
    logic [NUM_HOLES-1:0] mole;
    logic [3:0]           score_ones;
    logic [3:0]           score_tens;
    logic                 game_over;

    modport master (
        output start_btn, whack, timer_signal,
        input  game_start, timer_clear, mole, score_ones, score_tens, game_over
    );

    modport slave (
        input  start_btn, whack, timer_signal,
        output game_start, timer_clear, mole, score_ones, score_tens, game_over
    );
endinterface

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game controller: LFSR mole selection, mole lifetime, BCD score.
// Define WHACK_MISS_PENALTY_EN to subtract a point for whacking an unlit hole.
module whack_game_ctrl #(
    parameter int unsigned NUM_HOLES  = 4,
    parameter int unsigned MOLE_TICKS = 50000000,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input logic              clk,
    input logic              reset,
    whack_game_ctrl_if.slave bus
);
    localparam int unsigned IdxW = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
    localparam int unsigned CntW = 27;
    localparam logic [CntW-1:0] Reload = CntW'(MOLE_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StArm, StPlaying, StOver} state_e;

    state_e               state_q, state_d;
    logic [7:0]           lfsr_q, lfsr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d, idx_new;
    logic [NUM_HOLES-1:0] mole_q, mole_d, mole_new;
    logic [NUM_HOLES-1:0] whack_q, whack_edge;
    logic                 start_q, start_edge, edge_ok_q;
    logic [3:0]           ones_q, ones_d, tens_q, tens_d;
    logic                 game_start_q, timer_clear_q, game_over_q;
    logic                 hit, expire;

    // edge_ok_q masks the first cycle after reset, when the history regs are still zero
    assign start_edge = edge_ok_q & bus.start_btn & ~start_q;
    assign whack_edge = {NUM_HOLES{edge_ok_q}} & bus.whack & ~whack_q;

    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign idx_new  = (lfsr_q[IdxW-1:0] == idx_q) ? idx_q + IdxW'(1) : lfsr_q[IdxW-1:0];
    assign mole_new = {{(NUM_HOLES-1){1'b0}}, 1'b1} << idx_new;

    assign hit    = (state_q == StPlaying) && (|(whack_edge & mole_q));
    assign expire = (state_q == StPlaying) && (cnt_q == '0);

`ifdef WHACK_MISS_PENALTY_EN
    logic miss;
    assign miss = (state_q == StPlaying) && (|(whack_edge & ~mole_q));
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mole_d  = mole_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        unique case (state_q)
            StIdle: begin
                if (start_edge) state_d = StArm;
            end
            StArm: begin
                state_d = StPlaying;
                idx_d   = idx_new;
                cnt_d   = Reload;
                mole_d  = mole_new;
            end
            StPlaying: begin
                if (hit || expire) begin
                    idx_d  = idx_new;
                    cnt_d  = Reload;
                    mole_d = mole_new;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
                if (hit) begin
                    if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
                        if (ones_q == 4'd9) begin
                            ones_d = 4'd0;
                            tens_d = tens_q + 4'd1;
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                    end
                end
`ifdef WHACK_MISS_PENALTY_EN
                else if (miss) begin
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else if (tens_q != 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end
                end
`endif
                if (bus.timer_signal) state_d = StOver;
            end
            StOver: begin
                if (start_edge) state_d = StArm;
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StArm) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end
        if (state_d != StPlaying) mole_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            lfsr_q        <= LFSR_SEED;
            cnt_q         <= Reload;
            idx_q         <= '0;
            mole_q        <= '0;
            ones_q        <= 4'd0;
            tens_q        <= 4'd0;
            start_q       <= 1'b0;
            whack_q       <= '0;
            edge_ok_q     <= 1'b0;
            game_start_q  <= 1'b0;
            timer_clear_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            mole_q        <= mole_d;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
            start_q       <= bus.start_btn;
            whack_q       <= bus.whack;
            edge_ok_q     <= 1'b1;
            game_start_q  <= (state_d == StPlaying);
            timer_clear_q <= (state_d == StArm);
            game_over_q   <= (state_d == StOver);
        end
    end

    assign bus.game_start  = game_start_q;
    assign bus.timer_clear = timer_clear_q;
    assign bus.game_over   = game_over_q;
    assign bus.mole        = mole_q;
    assign bus.score_ones  = ones_q;
    assign bus.score_tens  = tens_q;
endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed bench for whack_game_ctrl (NUM_HOLES=4, MOLE_TICKS=8) with an
// independent LFSR/mole-pick model for predicting each new mole.
module tb_whack_game_ctrl;
    localparam int unsigned NH = 4;
    localparam int unsigned MT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    whack_game_ctrl_if #(.NUM_HOLES(NH)) bus ();

    whack_game_ctrl #(
        .NUM_HOLES (NH),
        .MOLE_TICKS(MT),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp     = 0;
    int         n_bad     = 0;
    int         exp_score = 0;
    logic [1:0] exp_idx   = 2'd0;
    logic [7:0] m_lfsr    = 8'hA5;
    logic [7:0] sel_lfsr  = 8'hA5;

    // sel_lfsr holds the LFSR value the DUT used at the most recent edge
    always @(posedge clk) begin
        sel_lfsr <= m_lfsr;
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [1:0] pick(input logic [7:0] l, input logic [1:0] cur);
        logic [1:0] c;
        c = l[1:0];
        return (c == cur) ? cur + 2'd1 : c;
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    function automatic logic [3:0] unlit(input logic [1:0] i);
        logic [1:0] j;
        j = i + 2'd1;
        return 4'b0001 << j;
    endfunction

    function automatic logic [7:0] bcd(input int s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus.start_btn    = 1'b1;
        bus.whack        = 4'h0;
        bus.timer_signal = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.game_start, bus.timer_clear, bus.game_over} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 000",
                     {bus.game_start, bus.timer_clear, bus.game_over});
        end
        n_cmp++;
        if (bus.mole !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_mole: got %h expected 0", bus.mole);
        end
        n_cmp++;
        if ({bus.score_tens, bus.score_ones} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_score: got %h expected 00", {bus.score_tens, bus.score_ones});
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (bus.timer_clear !== 1'b0) begin
            n_bad++;
            $display("FAIL no_edge_after_reset: got timer_clear=%b expected 0", bus.timer_clear);
        end
        tick();
        n_cmp++;
        if (bus.game_start !== 1'b0) begin
            n_bad++;
            $display("FAIL held_start_ignored: got game_start=%b expected 0", bus.game_start);
        end
        bus.start_btn = 1'b0;
        tick();
        exp_idx   = 2'd0;
        exp_score = 0;
    endtask

    task automatic test_start();
        bus.start_btn = 1'b1;
        tick();
        n_cmp++;
        if ({bus.game_start, bus.timer_clear, bus.game_over} !== 3'b010) begin
            n_bad++;
            $display("FAIL arm_flags: got %b expected 010",
                     {bus.game_start, bus.timer_clear, bus.game_over});
        end
        n_cmp++;
        if ({bus.mole, bus.score_tens, bus.score_ones} !== 12'h000) begin
            n_bad++;
            $display("FAIL arm_mole_score: got %h expected 000",
                     {bus.mole, bus.score_tens, bus.score_ones});
        end
        bus.start_btn = 1'b0;
        tick();
        exp_idx = pick(sel_lfsr, exp_idx);
        n_cmp++;
        if ({bus.game_start, bus.timer_clear, bus.game_over} !== 3'b100) begin
            n_bad++;
            $display("FAIL play_flags: got %b expected 100",
                     {bus.game_start, bus.timer_clear, bus.game_over});
        end
        n_cmp++;
        if (bus.mole !== oh(exp_idx)) begin
            n_bad++;
            $display("FAIL first_mole: got %b expected %b", bus.mole, oh(exp_idx));
        end
    endtask

    task automatic test_expiry();
        logic [1:0] old;
        old = exp_idx;
        for (int i = 1; i < int'(MT); i++) begin
            tick();
            n_cmp++;
            if (bus.mole !== oh(old)) begin
                n_bad++;
                $display("FAIL mole_held_cycle%0d: got %b expected %b", i, bus.mole, oh(old));
            end
        end
        tick();
        exp_idx = pick(sel_lfsr, exp_idx);
        n_cmp++;
        if (bus.mole !== oh(exp_idx)) begin
            n_bad++;
            $display("FAIL expiry_mole: got %b expected %b", bus.mole, oh(exp_idx));
        end
        n_cmp++;
        if ({bus.score_tens, bus.score_ones} !== 8'h00) begin
            n_bad++;
            $display("FAIL expiry_score: got %h expected 00", {bus.score_tens, bus.score_ones});
        end
    endtask

    task automatic test_hits();
        logic [1:0] old;
        for (int i = 0; i < 12; i++) begin
            old       = exp_idx;
            bus.whack = oh(exp_idx);
            tick();
            bus.whack = 4'h0;
            exp_score++;
            exp_idx = pick(sel_lfsr, exp_idx);
            n_cmp++;
            if ({bus.score_tens, bus.score_ones} !== bcd(exp_score)) begin
                n_bad++;
                $display("FAIL hit_score: got %h expected %h",
                         {bus.score_tens, bus.score_ones}, bcd(exp_score));
            end
            n_cmp++;
            if (bus.mole !== oh(exp_idx) || bus.mole === oh(old)) begin
                n_bad++;
                $display("FAIL hit_new_mole: got %b expected %b (previous %b)",
                         bus.mole, oh(exp_idx), oh(old));
            end
            tick();
        end
        n_cmp++;
        if ({bus.score_tens, bus.score_ones} !== 8'h12) begin
            n_bad++;
            $display("FAIL twelve_hits: got %h expected 12", {bus.score_tens, bus.score_ones});
        end
    endtask

    task automatic test_multi_whack();
        bus.whack = 4'hF;
        tick();
        bus.whack = 4'h0;
        exp_score++;
        exp_idx = pick(sel_lfsr, exp_idx);
        n_cmp++;
        if ({bus.score_tens, bus.score_ones} !== bcd(exp_score)) begin
            n_bad++;
            $display("FAIL multi_whack_score: got %h expected %h",
                     {bus.score_tens, bus.score_ones}, bcd(exp_score));
        end
        n_cmp++;
        if (bus.mole !== oh(exp_idx)) begin
            n_bad++;
            $display("FAIL multi_whack_mole: got %b expected %b", bus.mole, oh(exp_idx));
        end
        tick();
    endtask

    task automatic test_ignored_inputs();
        bus.start_btn = 1'b1;
        tick();
        n_cmp++;
        if ({bus.game_start, bus.timer_clear, bus.mole} !== {2'b10, oh(exp_idx)}) begin
            n_bad++;
            $display("FAIL start_ignored: got %b expected %b",
                     {bus.game_start, bus.timer_clear, bus.mole}, {2'b10, oh(exp_idx)});
        end
        bus.start_btn = 1'b0;
        bus.whack     = unlit(exp_idx);
        tick();
        bus.whack = 4'h0;
`ifdef WHACK_MISS_PENALTY_EN
        exp_score--;
`endif
        n_cmp++;
        if ({bus.score_tens, bus.score_ones} !== bcd(exp_score)) begin
            n_bad++;
            $display("FAIL miss_score: got %h expected %h",
                     {bus.score_tens, bus.score_ones}, bcd(exp_score));
        end
        n_cmp++;
        if (bus.mole !== oh(exp_idx)) begin
            n_bad++;
            $display("FAIL miss_keeps_mole: got %b expected %b", bus.mole, oh(exp_idx));
        end
        tick();
    endtask

    task automatic test_timer_hit();
        bus.whack        = oh(exp_idx);
        bus.timer_signal = 1'b1;
        tick();
        bus.whack        = 4'h0;
        bus.timer_signal = 1'b0;
        exp_score        = (exp_score < 99) ? exp_score + 1 : 99;
        exp_idx          = pick(sel_lfsr, exp_idx);
        n_cmp++;
        if ({bus.score_tens, bus.score_ones} !== bcd(exp_score)) begin
            n_bad++;
            $display("FAIL timer_hit_score: got %h expected %h",
                     {bus.score_tens, bus.score_ones}, bcd(exp_score));
        end
        n_cmp++;
        if ({bus.game_start, bus.timer_clear, bus.game_over, bus.mole} !== 7'b001_0000) begin
            n_bad++;
            $display("FAIL over_flags_mole: got %b expected 0010000",
                     {bus.game_start, bus.timer_clear, bus.game_over, bus.mole});
        end
    endtask

    task automatic test_over();
        bus.timer_signal = 1'b1;
        bus.whack        = 4'hF;
        tick();
        bus.timer_signal = 1'b0;
        bus.whack        = 4'h0;
        n_cmp++;
        if ({bus.game_over, bus.score_tens, bus.score_ones} !== {1'b1, bcd(exp_score)}) begin
            n_bad++;
            $display("FAIL over_hold: got %h expected %h",
                     {bus.game_over, bus.score_tens, bus.score_ones}, {1'b1, bcd(exp_score)});
        end
        tick();
        bus.start_btn = 1'b1;
        tick();
        exp_score = 0;
        n_cmp++;
        if ({bus.game_start, bus.timer_clear, bus.game_over, bus.score_tens, bus.score_ones}
            !== 11'b010_0000_0000) begin
            n_bad++;
            $display("FAIL restart_arm: got %b expected 01000000000",
                     {bus.game_start, bus.timer_clear, bus.game_over,
                      bus.score_tens, bus.score_ones});
        end
        bus.start_btn = 1'b0;
        tick();
        exp_idx = pick(sel_lfsr, exp_idx);
        n_cmp++;
        if ({bus.game_start, bus.mole} !== {1'b1, oh(exp_idx)}) begin
            n_bad++;
            $display("FAIL restart_play: got %b expected %b",
                     {bus.game_start, bus.mole}, {1'b1, oh(exp_idx)});
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 100; i++) begin
            bus.whack = oh(exp_idx);
            tick();
            bus.whack = 4'h0;
            exp_score = (exp_score < 99) ? exp_score + 1 : 99;
            exp_idx   = pick(sel_lfsr, exp_idx);
            n_cmp++;
            if ({bus.score_tens, bus.score_ones, bus.mole} !== {bcd(exp_score), oh(exp_idx)})
            begin
                n_bad++;
                $display("FAIL sat_hit%0d: got score %h mole %b expected score %h mole %b", i,
                         {bus.score_tens, bus.score_ones}, bus.mole, bcd(exp_score),
                         oh(exp_idx));
            end
            tick();
        end
        test_timer_hit();
    endtask

    task automatic test_penalty();
        bus.start_btn = 1'b1;
        tick();
        bus.start_btn = 1'b0;
        tick();
        exp_idx   = pick(sel_lfsr, exp_idx);
        exp_score = 0;
        bus.whack = unlit(exp_idx);
        tick();
        bus.whack = 4'h0;
        n_cmp++;
        if ({bus.score_tens, bus.score_ones} !== 8'h00) begin
            n_bad++;
            $display("FAIL miss_at_zero: got %h expected 00", {bus.score_tens, bus.score_ones});
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.whack = oh(exp_idx);
            tick();
            bus.whack = 4'h0;
            exp_idx   = pick(sel_lfsr, exp_idx);
            tick();
        end
        exp_score = 10;
        n_cmp++;
        if ({bus.score_tens, bus.score_ones} !== 8'h10) begin
            n_bad++;
            $display("FAIL ten_hits: got %h expected 10", {bus.score_tens, bus.score_ones});
        end
        bus.whack = unlit(exp_idx);
        tick();
        bus.whack = 4'h0;
`ifdef WHACK_MISS_PENALTY_EN
        exp_score = 9;
`endif
        n_cmp++;
        if ({bus.score_tens, bus.score_ones} !== bcd(exp_score)) begin
            n_bad++;
            $display("FAIL miss_from_ten: got %h expected %h",
                     {bus.score_tens, bus.score_ones}, bcd(exp_score));
        end
        bus.timer_signal = 1'b1;
        tick();
        bus.timer_signal = 1'b0;
        n_cmp++;
        if (bus.game_over !== 1'b1) begin
            n_bad++;
            $display("FAIL penalty_game_end: got game_over=%b expected 1", bus.game_over);
        end
    endtask

    task automatic test_reset_mid();
        bus.start_btn = 1'b1;
        tick();
        bus.start_btn = 1'b0;
        tick();
        exp_idx = pick(sel_lfsr, exp_idx);
        for (int i = 0; i < 5; i++) begin
            bus.whack = oh(exp_idx);
            tick();
            bus.whack = 4'h0;
            exp_idx   = pick(sel_lfsr, exp_idx);
            tick();
        end
        n_cmp++;
        if ({bus.game_start, bus.score_tens, bus.score_ones} !== 9'h105) begin
            n_bad++;
            $display("FAIL five_hits: got %h expected 105",
                     {bus.game_start, bus.score_tens, bus.score_ones});
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({bus.game_start, bus.timer_clear, bus.game_over, bus.mole,
             bus.score_tens, bus.score_ones} !== 15'h0) begin
            n_bad++;
            $display("FAIL reset_mid_game: got %h expected 0000",
                     {bus.game_start, bus.timer_clear, bus.game_over, bus.mole,
                      bus.score_tens, bus.score_ones});
        end
        reset   = 1'b0;
        exp_idx = 2'd0;
        tick();
        tick();
        n_cmp++;
        if ({bus.game_start, bus.timer_clear, bus.game_over} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b expected 000",
                     {bus.game_start, bus.timer_clear, bus.game_over});
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_expiry();
        test_hits();
        test_multi_whack();
        test_ignored_inputs();
        test_timer_hit();
        test_over();
        test_saturate();
        test_penalty();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench to finish");
        $fatal(1);
    end
endmodule

// File: doc/whack_game_ctrl.md
WHACK_GAME_CTRL -- requirements
Module: whack_game_ctrl

Interface
REQ-001 Parameter NUM_HOLES, default 4, number of mole holes; legal values 2, 4, 8.
REQ-002 Parameter MOLE_TICKS, default 50000000, clock cycles one mole stays lit; legal range 2 to 2^27-1.
REQ-003 Parameter LFSR_SEED, default 8'hA5, reset value of the mole LFSR; SHALL be nonzero.
REQ-004 Clock  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start_btn  input  1  level start request; internally rising-edge detected.
REQ-007 whack  input  NUM_HOLES  active-high hit requests, pre-debounced; internally rising-edge detected per bit.
REQ-008 timer_signal  input  1  level-high "time expired" from the game timer.
REQ-009 game_start  output  1  high while a game is running; enables the game timer.
REQ-010 timer_clear  output  1  one-cycle pulse that clears the game timer count.
REQ-011 mole  output  NUM_HOLES  one-hot lit hole, all-zero when none.
REQ-012 score_ones / score_tens  output  4 each  BCD score digits, 00-99.
REQ-013 game_over  output  1  high in OVER state.

Function
REQ-014 FSM states IDLE, ARM, PLAYING, OVER; all outputs registered.
REQ-015 IDLE: start_btn rising edge -> ARM; otherwise hold; mole=0, game_start=0.
REQ-016 ARM lasts exactly one cycle: timer_clear=1, score cleared to 00, lifetime counter loaded MOLE_TICKS-1, new mole selected; next state PLAYING.
REQ-017 PLAYING: game_start=1; mole lit; lifetime counter decrements each cycle.
REQ-018 Lifetime counter reaching 0 -> next cycle new mole selected, counter reloaded.
REQ-019 Hit = whack[i] rising edge with mole[i]=1; score increments, visible on outputs the cycle after the edge is sampled; new mole selected same cycle, counter reloaded.
REQ-020 Score is BCD: ones 9->0 with tens+1; saturates at 99.
REQ-021 Multiple whack edges in one cycle: only the lit hole counts; at most +1 per cycle.
REQ-022 Hit and lifetime expiry in same cycle: hit counted, single reload.
REQ-023 timer_signal high in PLAYING -> OVER next cycle; a hit in that same cycle is still counted.
REQ-024 OVER: mole=0, game_over=1, score held; start_btn rising edge -> ARM.
REQ-025 timer_signal ignored outside PLAYING; start_btn ignored in ARM and PLAYING.
REQ-026 LFSR 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle in all states.
REQ-027 Mole index = LFSR low log2(NUM_HOLES) bits; if equal to current index, use (index+1) mod NUM_HOLES.
REQ-028 Edge detectors use one register stage per input; no edge reported in the first cycle after reset.

Reset
REQ-029 reset dominates all other inputs in the cycle sampled.
REQ-030 Reset values: state IDLE, all outputs 0, score 00, LFSR=LFSR_SEED, lifetime counter MOLE_TICKS-1, edge registers 0.
REQ-031 Reset mid-game returns to IDLE in one cycle; no timer_clear pulse emitted.

Configuration
REQ-032 Macro WHACK_MISS_PENALTY_EN defined: whack rising edge on an unlit hole in PLAYING with no hit that cycle decrements score by 1 in BCD, saturating at 00; simultaneous hit takes priority.
REQ-033 Macro undefined: unlit-hole whacks are ignored; no penalty logic present.

Verification (MOLE_TICKS=8, NUM_HOLES=4)
REQ-034 reset 2 cycles, start_btn pulse -> one cycle timer_clear=1, then game_start=1, exactly one mole bit set.
REQ-035 Whack the lit hole 12 times -> score_tens=1, score_ones=2; each new mole differs from the previous.
REQ-036 No whacks for 8 cycles -> mole changes exactly at cycle 8; score unchanged 00.
REQ-037 Score at 99, one more hit -> stays 99; hit same cycle as timer_signal -> counted, then game_over=1, mole=0.
REQ-038 WHACK_MISS_PENALTY_EN: score 10, whack unlit hole -> 09; at 00, unlit whack -> 00; without macro -> unchanged.
REQ-039 reset asserted mid-PLAYING with score 05 -> next cycle IDLE, score 00, mole 0, timer_clear 0.
